// File: rtl/fpga_instruction_pkg.sv
// -----------------------------------------------------------------------------
// fpga_instruction_pkg
// Shared types and helpers for the PC-to-DUT instruction stream.
//   ser_state_t : serialiser FSM state encoding
//   ceil_div()  : integer ceiling division, used to derive byte and chunk counts
//   DROP_CNT_W  : width of the saturating lost-instruction counter
// -----------------------------------------------------------------------------
package fpga_instruction_pkg;

  localparam int DROP_CNT_W = 8;

  // Encoding chosen so every legal transition flips exactly one bit:
  // IDLE->LOAD->REQ<->ACK_LOW->IDLE. instruction_req decodes to REQ only,
  // so it cannot glitch on its way to the asynchronous receiver.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LOAD    = 2'b01,
    ST_REQ     = 2'b11,
    ST_ACK_LOW = 2'b10
  } ser_state_t;

  // NBYTES = ceil_div(INSTR_W, 8); NCHUNKS = ceil_div(INSTR_W, CHUNK_W).
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fpga_instruction_fifo.sv
// -----------------------------------------------------------------------------
// fpga_instruction_fifo
// Synchronous FIFO, parametrised width and depth (depth a power of two).
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_din (ignored when full unless a pop happens too)
//   i_pop     : read; o_dout shows the popped word from the next cycle
//   o_full    : registered, level == DEPTH
//   o_empty   : level == 0
//   o_level   : registered occupancy
// Push and pop in the same cycle are both honoured, including when full.
// -----------------------------------------------------------------------------
module fpga_instruction_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_full;
  logic [W-1:0]     r_dout;

  logic             w_do_push;
  logic             w_do_pop;
  logic [LVL_W-1:0] w_level_nxt;

  assign w_do_pop  = i_pop && (r_level != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_do_push && !w_do_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_W'(DEPTH));
    end
  end

  assign o_dout  = r_dout;
  assign o_full  = r_full;
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/fpga_instruction_stream.sv
// -----------------------------------------------------------------------------
// fpga_instruction_stream
// Assembles PC bytes (MSB first) into INSTR_W-bit instructions, buffers up to
// FIFO_DEPTH of them, and sends each one LSB chunk first as CHUNK_W-bit words
// over a 4-phase req/ack link.
//   clk, rst             : clock, asynchronous active-high reset
//   data_from_pc_valid   : one byte per high cycle on data_from_pc
//   instruction_ack      : acknowledge from the DUT (asynchronous, synchronised)
//   instruction_req      : request to the DUT
//   instruction_chunked  : current chunk, stable from req rise until ack_s low
//   instruction_last     : high while the final chunk is presented
//   full, fifo_level     : registered FIFO status
//   drop_count           : saturating count of lost instructions
//                          (overflow drops and inter-byte timeouts)
//   busy                 : serialiser not idle
//
// Link handshake: instruction_req rises with the chunk already stable; the DUT
// raises ack; once the synchronised ack is seen high, req falls; once it is
// seen low again the next chunk (or idle) follows. The chunk and last flag do
// not change anywhere inside that window.
// -----------------------------------------------------------------------------
module fpga_instruction_stream
  import fpga_instruction_pkg::*;
#(
  parameter int INSTR_W        = 147,
  parameter int CHUNK_W        = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_from_pc_valid,
  input  logic [7:0]                    data_from_pc,
  input  logic                          instruction_ack,
  output logic                          instruction_req,
  output logic [CHUNK_W-1:0]            instruction_chunked,
  output logic                          instruction_last,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic                          busy
);

  localparam int NBYTES  = ceil_div(INSTR_W, 8);
  localparam int NCHUNKS = ceil_div(INSTR_W, CHUNK_W);
  localparam int SHIFT_W = NBYTES * 8;
  localparam int PAD_W   = NCHUNKS * CHUNK_W;
  localparam int BCNT_W  = $clog2(NBYTES);
  localparam int IDX_W   = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam int IDLE_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // ---------------------------------------------------------------- assembler
  logic [SHIFT_W-1:0] r_shift;
  logic [BCNT_W-1:0]  r_byte_cnt;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_push;
  logic               w_timeout;

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_byte_cnt != '0) &&
                     (r_idle == IDLE_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_idle     <= '0;
      r_push     <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (data_from_pc_valid) begin
        r_shift <= {r_shift[SHIFT_W-9:0], data_from_pc};
        r_idle  <= '0;
        if (w_timeout) begin
          // Partial instruction abandoned; this byte starts a fresh one.
          r_byte_cnt <= BCNT_W'(1);
        end else if (r_byte_cnt == BCNT_W'(NBYTES - 1)) begin
          r_byte_cnt <= '0;
          r_push     <= 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
        end
      end else if (w_timeout) begin
        r_byte_cnt <= '0;
        r_idle     <= '0;
      end else if (r_byte_cnt != '0) begin
        r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------- FIFO
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [INSTR_W-1:0] w_fifo_dout;

  // Only the low INSTR_W bits matter; excess top bits of the first byte fall off.
  fpga_instruction_fifo #(
    .W     (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_din   (r_shift[INSTR_W-1:0]),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  // ------------------------------------------------------------ drop counter
  logic                  w_ovf;
  logic [DROP_CNT_W:0]   w_drop_sum;
  logic [DROP_CNT_W-1:0] r_drop;

  assign w_ovf      = r_push && w_fifo_full && !w_pop;
  // An overflow and a timeout can land in the same cycle, hence up to +2.
  assign w_drop_sum = {1'b0, r_drop} + (DROP_CNT_W + 1)'(w_ovf) +
                      (DROP_CNT_W + 1)'(w_timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else begin
      r_drop <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
    end
  end

  // -------------------------------------------------------- ack synchroniser
  logic r_ack_meta;
  logic r_ack_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= instruction_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // --------------------------------------------------------------- serialiser
  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [PAD_W-1:0] r_word;
  logic [IDX_W-1:0] r_idx;
  logic             w_is_last;

  assign w_is_last = (r_idx == IDX_W'(NCHUNKS - 1));
  assign w_pop     = (r_state == ST_IDLE) && !w_fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (!w_fifo_empty) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_REQ;
      ST_REQ:     if (r_ack_s) w_state_nxt = ST_ACK_LOW;
      ST_ACK_LOW: if (!r_ack_s) w_state_nxt = w_is_last ? ST_IDLE : ST_REQ;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Word register is zero-extended, so the final chunk reads zeros above INSTR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_word <= PAD_W'(w_fifo_dout);
        r_idx  <= '0;
      end else if (r_state == ST_ACK_LOW && !r_ack_s && !w_is_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    instruction_req     = 1'b0;
    instruction_chunked = '0;
    instruction_last    = 1'b0;
    busy                = (r_state != ST_IDLE);
    if (r_state == ST_REQ || r_state == ST_ACK_LOW) begin
      instruction_req     = (r_state == ST_REQ);
      instruction_chunked = r_word[r_idx*CHUNK_W +: CHUNK_W];
      instruction_last    = w_is_last;
    end
  end

  assign full       = w_fifo_full;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_fpga_instruction_stream.sv
module tb_fpga_instruction_stream;

  localparam int INSTR_W = 147;
  localparam int CHUNK_W = 32;
  localparam int NBYTES  = 19;
  localparam int NCHUNKS = 5;
  localparam int TMO     = 10;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               data_from_pc_valid;
  logic [7:0]         data_from_pc;
  logic               instruction_req;
  logic [CHUNK_W-1:0] instruction_chunked;
  logic               instruction_last;
  logic               full;
  logic [2:0]         fifo_level;
  logic [7:0]         drop_count;
  logic               busy;

  // The ack line is either driven by the auto responder or by hand.
  logic use_manual;
  logic man_ack;
  logic resp_ack;
  logic ack_w;
  assign ack_w = use_manual ? man_ack : resp_ack;

  fpga_instruction_stream #(
    .INSTR_W        (INSTR_W),
    .CHUNK_W        (CHUNK_W),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_from_pc_valid  (data_from_pc_valid),
    .data_from_pc        (data_from_pc),
    .instruction_ack     (ack_w),
    .instruction_req     (instruction_req),
    .instruction_chunked (instruction_chunked),
    .instruction_last    (instruction_last),
    .full                (full),
    .fifo_level          (fifo_level),
    .drop_count          (drop_count),
    .busy                (busy)
  );

  // ------------------------------------------------------------ scoreboard
  logic [CHUNK_W:0] exp_q[$];   // {last, chunk}
  int checks = 0;
  int errors = 0;
  int chunks_seen = 0;
  bit slow_ack = 1'b0;
  int exp_drop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chunk k of an instruction: k-th CHUNK_W slice of the zero-extended word.
  function automatic logic [CHUNK_W:0] exp_chunk(input logic [INSTR_W-1:0] v, input int k);
    logic [NCHUNKS*CHUNK_W-1:0] wide;
    wide = '0;
    wide[INSTR_W-1:0] = v;
    wide = wide >> (k * CHUNK_W);
    return {(k == NCHUNKS - 1), wide[CHUNK_W-1:0]};
  endfunction

  task automatic queue_instr(input logic [INSTR_W-1:0] v);
    for (int k = 0; k < NCHUNKS; k++) exp_q.push_back(exp_chunk(v, k));
  endtask

  function automatic logic [INSTR_W-1:0] rand_instr();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[INSTR_W-1:0];
  endfunction

  // ---------------------------------------------------------------- drivers
  // Tasks start and end on a falling edge. Junk goes into the unused top bits.
  task automatic send_instr(input logic [INSTR_W-1:0] v, input int max_gap);
    logic [NBYTES*8-1:0] fullw;
    fullw = {5'($urandom_range(0, 31)), v};
    for (int i = 0; i < NBYTES; i++) begin
      data_from_pc_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      data_from_pc_valid = 1'b1;
      data_from_pc = fullw[NBYTES*8-1-8*i -: 8];
      @(negedge clk);
    end
    data_from_pc_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy || fifo_level != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_in_time", cyc < budget, 1);
  endtask

  // Manual handshake of one chunk; optionally leaves ack high (ACK_LOW held).
  task automatic man_chunk(input string tag, input logic [CHUNK_W:0] exp, input bit drop_ack);
    int cyc = 0;
    while (!instruction_req && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, "_req_rise"}, instruction_req, 1);
    chk(tag, {instruction_last, instruction_chunked}, exp);
    man_ack = 1'b1;
    cyc = 0;
    while (instruction_req && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, "_req_fall"}, instruction_req, 0);
    chk({tag, "_hold"}, {instruction_last, instruction_chunked}, exp);
    if (drop_ack) begin
      man_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  // ------------------------------------------------------- auto responder
  initial begin
    logic [CHUNK_W:0] held;
    logic [CHUNK_W:0] exp;
    int d;
    int cyc;
    resp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!use_manual && !rst && instruction_req && !resp_ack) begin
        held = {instruction_last, instruction_chunked};
        chk("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          chk("chunk", held, exp);
        end
        chunks_seen++;
        d = slow_ack ? 20 : $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          chk("req_held", instruction_req, 1);
          chk("stable_req", {instruction_last, instruction_chunked}, held);
        end
        resp_ack = 1'b1;
        cyc = 0;
        while (instruction_req && cyc < 200) begin
          @(negedge clk);
          cyc++;
          chk("stable_wait_fall", {instruction_last, instruction_chunked}, held);
        end
        chk("req_fall", instruction_req, 0);
        d = slow_ack ? 20 : $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          chk("stable_ack_high", {instruction_last, instruction_chunked}, held);
        end
        resp_ack = 1'b0;
        // Two more cycles until the synchronised ack is seen low.
        repeat (2) begin
          @(negedge clk);
          chk("stable_ack_low", {instruction_last, instruction_chunked}, held);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- main test
  initial begin
    logic [INSTR_W-1:0] v;
    logic [INSTR_W-1:0] b[7];
    logic [INSTR_W-1:0] v8;
    logic [NBYTES*8-1:0] fullw;
    int seen0;

    rst = 1'b1;
    data_from_pc_valid = 1'b0;
    data_from_pc = 8'h00;
    use_manual = 1'b0;
    man_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", instruction_req, 0);
    chk("rst_chunk", instruction_chunked, 0);
    chk("rst_last", instruction_last, 0);
    chk("rst_full", full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed single instruction.
    v = 147'h5_0123_4567_89AB_CDEF_0011_2233_4455_6677;
    seen0 = chunks_seen;
    queue_instr(v);
    send_instr(v, 0);
    wait_drain(1000);
    chk("single_nchunks", chunks_seen - seen0, 5);

    // Random traffic, at most three in flight so nothing is dropped.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        v = rand_instr();
        queue_instr(v);
        send_instr(v, 3);
      end
      wait_drain(3000);
    end
    chk("random_no_drop", drop_count, exp_drop);

    // Slow ack: responder checks stability throughout each handshake.
    slow_ack = 1'b1;
    v = rand_instr();
    queue_instr(v);
    send_instr(v, 0);
    wait_drain(3000);
    slow_ack = 1'b0;

    // Backpressure: ack held low. The serialiser takes instruction 1, the
    // FIFO holds 2..5, and 6 and 7 are dropped.
    use_manual = 1'b1;
    man_ack = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      b[k-1] = rand_instr();
      send_instr(b[k-1], 0);
      repeat (3) @(negedge clk);
      if (k >= 6) exp_drop++;
      chk("bp_level", fifo_level, (k - 1 > 4) ? 4 : k - 1);
      chk("bp_full", full, (k >= 5) ? 1 : 0);
      chk("bp_drop", drop_count, exp_drop);
    end

    // Finish instruction 1 by hand, holding ack on its last chunk.
    for (int k = 0; k < NCHUNKS - 1; k++) man_chunk("bp_first", exp_chunk(b[0], k), 1'b1);
    man_chunk("bp_first_last", exp_chunk(b[0], NCHUNKS - 1), 1'b0);

    // Collision: release ack so IDLE pops exactly when the new push lands.
    v8 = rand_instr();
    fullw = {5'($urandom_range(0, 31)), v8};
    for (int i = 0; i < NBYTES; i++) begin
      if (i == NBYTES - 3) man_ack = 1'b0;
      data_from_pc_valid = 1'b1;
      data_from_pc = fullw[NBYTES*8-1-8*i -: 8];
      @(negedge clk);
    end
    data_from_pc_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("coll_level", fifo_level, 4);
    chk("coll_full", full, 1);
    chk("coll_drop", drop_count, exp_drop);

    // Drain: buffered instructions in order, then the collided one.
    for (int k = 1; k <= 4; k++) queue_instr(b[k]);
    queue_instr(v8);
    seen0 = chunks_seen;
    use_manual = 1'b0;
    wait_drain(4000);
    chk("drain_nchunks", chunks_seen - seen0, 25);
    chk("drain_drop", drop_count, exp_drop);

    // Timeout: 7 bytes, stall, then a full instruction.
    for (int i = 0; i < 7; i++) begin
      data_from_pc_valid = 1'b1;
      data_from_pc = 8'($urandom);
      @(negedge clk);
    end
    data_from_pc_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo_not_yet", drop_count, exp_drop);
    repeat (8) @(negedge clk);
    exp_drop++;
    chk("tmo_drop", drop_count, exp_drop);
    v = rand_instr();
    queue_instr(v);
    seen0 = chunks_seen;
    send_instr(v, 0);
    wait_drain(1000);
    repeat (20) @(negedge clk);
    chk("tmo_one_instr", chunks_seen - seen0, 5);
    chk("tmo_idle", busy, 0);
    chk("tmo_drop_after", drop_count, exp_drop);

    // Mid-transfer reset while in ACK_LOW on chunk 3, one more buffered.
    use_manual = 1'b1;
    man_ack = 1'b0;
    v = rand_instr();
    send_instr(v, 0);
    send_instr(rand_instr(), 0);
    for (int k = 0; k < 3; k++) man_chunk("mr_chunk", exp_chunk(v, k), 1'b1);
    man_chunk("mr_chunk3", exp_chunk(v, 3), 1'b0);
    chk("mr_level_before", fifo_level, 1);
    rst = 1'b1;
    #1;
    exp_drop = 0;
    chk("mr_req", instruction_req, 0);
    chk("mr_level", fifo_level, 0);
    chk("mr_drop", drop_count, 0);
    chk("mr_busy", busy, 0);
    chk("mr_chunk_out", instruction_chunked, 0);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    use_manual = 1'b0;
    v = rand_instr();
    queue_instr(v);
    seen0 = chunks_seen;
    send_instr(v, 2);
    wait_drain(1000);
    chk("mr_clean_nchunks", chunks_seen - seen0, 5);

    // Drop counter saturation via repeated single-byte timeouts.
    for (int i = 0; i < 260; i++) begin
      data_from_pc_valid = 1'b1;
      data_from_pc = 8'($urandom);
      @(negedge clk);
      data_from_pc_valid = 1'b0;
      repeat (12) @(negedge clk);
      if (exp_drop < 255) exp_drop++;
      if (i == 100) chk("sat_mid", drop_count, exp_drop);
    end
    chk("sat_drop", drop_count, 255);
    chk("sat_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
